trojan_output_monitor: RTL and testbench

// - Downstream checker for the 16-bit registered data-path stage: consumes the stage's input
//   (ref_in) and its registered output (dut_in) and verifies dut_in == ref_in delayed by LAT cycles.
// - Counts mismatches, captures the first offending sample, raises a sticky alarm at threshold.
// - Golden-model monitor for trojan-payload benches and for in-silicon integrity monitoring.

---
 rtl/trojan_output_monitor_if.sv | 33 +++
 rtl/trojan_output_monitor.sv | 183 ++++++++++++++++++
 tb/tb_trojan_output_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trojan_output_monitor_if.sv
// Bus bundle between a data-path stage under observation and its output monitor.
// The master side drives the observed samples and controls; the slave side is the monitor.
interface trojan_output_monitor_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned IDX_W = 16;

   logic                enable;
   logic                clr;
   logic                in_valid;
   logic [WIDTH-1:0]    ref_in;
   logic [WIDTH-1:0]    dut_in;
   logic [1:0]          state_out;
   logic [CNT_W-1:0]    mismatch_cnt;
   logic                alarm;
   logic [WIDTH-1:0]    diff_out;
   logic [WIDTH-1:0]    first_bad_ref;
   logic [WIDTH-1:0]    first_bad_dut;
   logic [IDX_W-1:0]    first_bad_idx;

   modport master (
      output enable, clr, in_valid, ref_in, dut_in,
      input  state_out, mismatch_cnt, alarm, diff_out,
             first_bad_ref, first_bad_dut, first_bad_idx
   );

   modport slave (
      input  enable, clr, in_valid, ref_in, dut_in,
      output state_out, mismatch_cnt, alarm, diff_out,
             first_bad_ref, first_bad_dut, first_bad_idx
   );
endinterface

// File: rtl/trojan_output_monitor.sv
// Output integrity monitor for a registered data-path stage.
// Delays the stage input by LAT cycles, compares it against the stage output,
// counts mismatches (saturating), captures the first offending sample and raises
// a sticky alarm once the mismatch count reaches THRESH.
module trojan_output_monitor #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned LAT    = 1,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned THRESH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   trojan_output_monitor_if.slave mon
);

   localparam int unsigned IDX_W   = 16;
   localparam int unsigned WARM_W  = 4;
   localparam int unsigned LAST    = LAT - 1;

   localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
   localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_ARMED  = 2'd2,
      ST_ALARM  = 2'd3
   } state_e;

   state_e                       state_q, state_d;
   logic [WARM_W-1:0]            warm_q, warm_d;
   logic [LAT-1:0]               vpipe_q, vpipe_d;
   logic [LAT-1:0][WIDTH-1:0]    rpipe_q, rpipe_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [WIDTH-1:0]             diff_q, diff_d;
   logic [WIDTH-1:0]             fb_ref_q, fb_ref_d;
   logic [WIDTH-1:0]             fb_dut_q, fb_dut_d;
   logic [IDX_W-1:0]             fb_idx_q, fb_idx_d;
   logic                         seen_q, seen_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         alarm_q, alarm_d;

   logic                         v_dly_c;
   logic [WIDTH-1:0]             ref_dly_c;
   logic                         cmp_c;
   logic                         mism_c;

   // Delay line: free-running shift of {in_valid, ref_in}, independent of state and valid.
   always_comb begin
      vpipe_d    = '0;
      rpipe_d    = '0;
      vpipe_d[0] = mon.in_valid;
      rpipe_d[0] = mon.ref_in;
      for (int unsigned i = 1; i < LAT; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
         rpipe_d[i] = rpipe_q[i-1];
      end
   end

   assign v_dly_c   = vpipe_q[LAST];
   assign ref_dly_c = rpipe_q[LAST];

   // A compare needs an armed monitor and a valid delayed sample; clr suppresses it.
   assign cmp_c  = ((state_q == ST_ARMED) || (state_q == ST_ALARM)) && v_dly_c && !mon.clr;
   assign mism_c = (mon.dut_in != ref_dly_c);

   // Next-state, compare results, capture and index update.
   always_comb begin
      state_d  = state_q;
      warm_d   = warm_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      fb_ref_d = fb_ref_q;
      fb_dut_d = fb_dut_q;
      fb_idx_d = fb_idx_q;
      seen_d   = seen_q;
      idx_d    = idx_q;

      if (mon.clr) begin
         cnt_d    = '0;
         diff_d   = '0;
         fb_ref_d = '0;
         fb_dut_d = '0;
         fb_idx_d = '0;
         seen_d   = 1'b0;
         idx_d    = '0;
         warm_d   = '0;
         state_d  = mon.enable ? ST_WARMUP : ST_IDLE;
      end else begin
         if (cmp_c) begin
            diff_d = mon.dut_in - ref_dly_c;
            idx_d  = idx_q + IDX_W'(1);
            if (mism_c) begin
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (!seen_q) begin
                  fb_ref_d = ref_dly_c;
                  fb_dut_d = mon.dut_in;
                  fb_idx_d = idx_q;
                  seen_d   = 1'b1;
               end
            end
         end

         if (!mon.enable) begin
            state_d = ST_IDLE;
            warm_d  = '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  state_d = ST_WARMUP;
                  warm_d  = '0;
               end
               ST_WARMUP: begin
                  // Delay line holds LAT fresh samples once LAT cycles have elapsed here.
                  if (warm_q == WARM_LAST) begin
                     state_d = ST_ARMED;
                     warm_d  = '0;
                     idx_d   = '0;
                  end else begin
                     warm_d  = warm_q + WARM_W'(1);
                  end
               end
               ST_ARMED: begin
                  if (cmp_c && mism_c && (cnt_d >= THRESH_C)) begin
                     state_d = ST_ALARM;
                  end
               end
               ST_ALARM: begin
                  state_d = ST_ALARM;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end

      alarm_d = (state_d == ST_ALARM);
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         warm_q   <= '0;
         vpipe_q  <= '0;
         rpipe_q  <= '0;
         cnt_q    <= '0;
         diff_q   <= '0;
         fb_ref_q <= '0;
         fb_dut_q <= '0;
         fb_idx_q <= '0;
         seen_q   <= 1'b0;
         idx_q    <= '0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         warm_q   <= warm_d;
         vpipe_q  <= vpipe_d;
         rpipe_q  <= rpipe_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         fb_ref_q <= fb_ref_d;
         fb_dut_q <= fb_dut_d;
         fb_idx_q <= fb_idx_d;
         seen_q   <= seen_d;
         idx_q    <= idx_d;
         alarm_q  <= alarm_d;
      end
   end

   assign mon.state_out     = state_q;
   assign mon.mismatch_cnt  = cnt_q;
   assign mon.alarm         = alarm_q;
   assign mon.diff_out      = diff_q;
   assign mon.first_bad_ref = fb_ref_q;
   assign mon.first_bad_dut = fb_dut_q;
   assign mon.first_bad_idx = fb_idx_q;

endmodule

// File: tb/tb_trojan_output_monitor.sv
// Bench for trojan_output_monitor: two instances (LAT=1/THRESH=1 and LAT=3/THRESH=3)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_trojan_output_monitor;

   localparam int LAT_A = 1;
   localparam int TH_A  = 1;
   localparam int LAT_B = 3;
   localparam int TH_B  = 3;

   logic clk;
   logic rst;

   trojan_output_monitor_if #(.WIDTH(16), .CNT_W(8)) if_a ();
   trojan_output_monitor_if #(.WIDTH(16), .CNT_W(8)) if_b ();

   trojan_output_monitor #(.WIDTH(16), .LAT(LAT_A), .CNT_W(8), .THRESH(TH_A)) dut_a (
      .clk (clk),
      .rst (rst),
      .mon (if_a)
   );

   trojan_output_monitor #(.WIDTH(16), .LAT(LAT_B), .CNT_W(8), .THRESH(TH_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .mon (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state, one slot per instance.
   int          lat_k [2];
   int          th_k  [2];
   int          m_mode[2];
   int          m_warm[2];
   int          m_cnt [2];
   int          m_idx [2];
   logic [15:0] m_diff[2];
   logic [15:0] m_fbr [2];
   logic [15:0] m_fbd [2];
   logic [15:0] m_fbi [2];
   bit          m_seen[2];
   logic [16:0] hist[$];

   int          ramp_next;
   logic [15:0] last_nz_a;

   typedef struct {
      bit          en;
      bit          cl;
      bit          v;
      logic [15:0] r;
      logic [15:0] d;
      logic [1:0]  st;
      logic [7:0]  cnt;
      bit          al;
      logic [15:0] diff;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // {valid, ref} that an instance of latency lat sees at its delay-line output now.
   function automatic logic [16:0] dly(input int lat);
      if (hist.size() >= lat) return hist[hist.size() - lat];
      return 17'd0;
   endfunction

   function automatic logic [15:0] dly_ref(input int lat);
      logic [16:0] s;
      s = dly(lat);
      return s[15:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_warm[k] = 0; m_cnt[k] = 0; m_idx[k] = 0;
         m_diff[k] = '0; m_fbr[k] = '0; m_fbd[k] = '0; m_fbi[k] = '0;
         m_seen[k] = 1'b0;
      end
      hist.delete();
   endtask

   task automatic model_step(input bit en, input bit cl, input bit v, input logic [15:0] r,
                             input logic [15:0] da, input logic [15:0] db);
      if (rst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         logic [16:0] s;
         logic [15:0] rd;
         logic [15:0] d;
         bit          vd;
         bit          cmp;
         bit          mis;
         s   = dly(lat_k[k]);
         vd  = s[16];
         rd  = s[15:0];
         d   = (k == 0) ? da : db;
         cmp = (m_mode[k] >= 2) && vd && !cl;
         mis = (d != rd);
         if (cl) begin
            m_cnt[k] = 0; m_diff[k] = '0; m_fbr[k] = '0; m_fbd[k] = '0; m_fbi[k] = '0;
            m_seen[k] = 1'b0; m_idx[k] = 0; m_warm[k] = 0;
            m_mode[k] = en ? 1 : 0;
         end else begin
            if (cmp) begin
               m_diff[k] = d - rd;
               if (mis) begin
                  if (!m_seen[k]) begin
                     m_fbr[k]  = rd;
                     m_fbd[k]  = d;
                     m_fbi[k]  = 16'(m_idx[k]);
                     m_seen[k] = 1'b1;
                  end
                  if (m_cnt[k] < 255) m_cnt[k]++;
               end
               m_idx[k] = (m_idx[k] + 1) % 65536;
            end
            if (!en) begin
               m_mode[k] = 0;
               m_warm[k] = 0;
            end else if (m_mode[k] == 0) begin
               m_mode[k] = 1;
               m_warm[k] = 0;
            end else if (m_mode[k] == 1) begin
               m_warm[k]++;
               if (m_warm[k] >= lat_k[k]) begin
                  m_mode[k] = 2;
                  m_warm[k] = 0;
                  m_idx[k]  = 0;
               end
            end else if (m_mode[k] == 2 && cmp && mis && m_cnt[k] >= th_k[k]) begin
               m_mode[k] = 3;
            end
         end
      end
      hist.push_back({v, r});
      if (hist.size() > 16) hist.delete(0);
   endtask

   task automatic check_inst(input int k, input logic [1:0] st, input logic [7:0] cnt,
                             input logic al, input logic [15:0] df, input logic [15:0] fr,
                             input logic [15:0] fd, input logic [15:0] fi);
      chk($sformatf("state_%0d", k),         32'(st),  32'(m_mode[k]));
      chk($sformatf("mismatch_cnt_%0d", k),  32'(cnt), 32'(m_cnt[k]));
      chk($sformatf("alarm_%0d", k),         32'(al),  32'(m_mode[k] == 3));
      chk($sformatf("diff_out_%0d", k),      32'(df),  32'(m_diff[k]));
      chk($sformatf("first_bad_ref_%0d", k), 32'(fr),  32'(m_fbr[k]));
      chk($sformatf("first_bad_dut_%0d", k), 32'(fd),  32'(m_fbd[k]));
      chk($sformatf("first_bad_idx_%0d", k), 32'(fi),  32'(m_fbi[k]));
   endtask

   task automatic check_all();
      check_inst(0, if_a.state_out, if_a.mismatch_cnt, if_a.alarm, if_a.diff_out,
                 if_a.first_bad_ref, if_a.first_bad_dut, if_a.first_bad_idx);
      check_inst(1, if_b.state_out, if_b.mismatch_cnt, if_b.alarm, if_b.diff_out,
                 if_b.first_bad_ref, if_b.first_bad_dut, if_b.first_bad_idx);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state_a"}, 32'(if_a.state_out),     32'd0);
      chk({tag, "_cnt_a"},   32'(if_a.mismatch_cnt),  32'd0);
      chk({tag, "_alarm_a"}, 32'(if_a.alarm),         32'd0);
      chk({tag, "_diff_a"},  32'(if_a.diff_out),      32'd0);
      chk({tag, "_fbr_a"},   32'(if_a.first_bad_ref), 32'd0);
      chk({tag, "_fbd_a"},   32'(if_a.first_bad_dut), 32'd0);
      chk({tag, "_fbi_a"},   32'(if_a.first_bad_idx), 32'd0);
      chk({tag, "_state_b"}, 32'(if_b.state_out),     32'd0);
      chk({tag, "_cnt_b"},   32'(if_b.mismatch_cnt),  32'd0);
      chk({tag, "_alarm_b"}, 32'(if_b.alarm),         32'd0);
   endtask

   // One clock: inputs set at the falling edge, model advanced at the rising edge,
   // outputs compared at the next falling edge.
   task automatic step(input bit en, input bit cl, input bit v, input logic [15:0] r,
                       input logic [15:0] da, input logic [15:0] db);
      if_a.enable = en; if_a.clr = cl; if_a.in_valid = v; if_a.ref_in = r; if_a.dut_in = da;
      if_b.enable = en; if_b.clr = cl; if_b.in_valid = v; if_b.ref_in = r; if_b.dut_in = db;
      @(posedge clk);
      model_step(en, cl, v, r, da, db);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      rst = 1'b0;
      ramp_next = 0;
      last_nz_a = '0;
   endtask

   // Enable with an idle sample so that ramp value N is compared at index N on both instances.
   task automatic start_mon();
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
   endtask

   // Ramp of n valid samples; stage output is the delayed ref, plus delta on listed ref values.
   task automatic run_ramp(input int n, input int b0, input int b1, input int b2,
                           input logic [15:0] delta);
      for (int i = 0; i < n; i++) begin
         logic [15:0] g  [2];
         logic [15:0] dd [2];
         logic [16:0] s;
         g[0] = dly_ref(lat_k[0]);
         g[1] = dly_ref(lat_k[1]);
         for (int k = 0; k < 2; k++) begin
            s = dly(lat_k[k]);
            dd[k] = g[k];
            if (s[16] && (g[k] == 16'(b0) || g[k] == 16'(b1) || g[k] == 16'(b2)))
               dd[k] = g[k] + delta;
         end
         step(1'b1, 1'b0, 1'b1, 16'(ramp_next), dd[0], dd[1]);
         ramp_next++;
         if (if_a.diff_out != 16'h0) last_nz_a = if_a.diff_out;
      end
   endtask

   initial begin
      lat_k[0] = LAT_A; lat_k[1] = LAT_B;
      th_k[0]  = TH_A;  th_k[1]  = TH_B;

      // Directed per-cycle sequence for the LAT=1/THRESH=1 instance: clr against a mismatch,
      // rearm, alarm, enable drop with held counters, re-entry.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1, 8'd0, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 2'd2, 8'd0, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 16'h0010, 2'd2, 8'd0, 1'b0, 16'h0000};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'h0012, 16'h0015, 2'd1, 8'd0, 1'b0, 16'h0000};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0013, 16'h0012, 2'd2, 8'd0, 1'b0, 16'h0000};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0014, 16'h0010, 2'd3, 8'd1, 1'b1, 16'hFFFD};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0014, 2'd3, 8'd1, 1'b1, 16'h0000};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h0099, 2'd3, 8'd1, 1'b1, 16'h0000};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 2'd0, 8'd1, 1'b0, 16'h0000};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 8'd1, 1'b0, 16'h0000};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1, 8'd1, 1'b0, 16'h0000};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, 2'd2, 8'd1, 1'b0, 16'h0000};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0030, 2'd2, 8'd1, 1'b0, 16'h0000};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd2, 8'd1, 1'b0, 16'h0000};

      rst = 1'b1;
      if_a.enable = 1'b0; if_a.clr = 1'b0; if_a.in_valid = 1'b0; if_a.ref_in = '0; if_a.dut_in = '0;
      if_b.enable = 1'b0; if_b.clr = 1'b0; if_b.in_valid = 1'b0; if_b.ref_in = '0; if_b.dut_in = '0;
      model_reset();
      ramp_next = 0;
      last_nz_a = '0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");

      // Clean ramp: no mismatches, diff stays zero.
      do_reset();
      start_mon();
      run_ramp(600, -1, -1, -1, 16'h0);
      chk("clean_state_a", 32'(if_a.state_out),    32'd2);
      chk("clean_cnt_a",   32'(if_a.mismatch_cnt), 32'd0);
      chk("clean_alarm_a", 32'(if_a.alarm),        32'd0);
      chk("clean_diff_nz", 32'(last_nz_a),         32'd0);
      chk("clean_state_b", 32'(if_b.state_out),    32'd2);

      // Single corruption on ref=255.
      do_reset();
      start_mon();
      run_ramp(600, 255, -1, -1, 16'h0002);
      chk("one_alarm_a", 32'(if_a.alarm),         32'd1);
      chk("one_cnt_a",   32'(if_a.mismatch_cnt),  32'd1);
      chk("one_fbr_a",   32'(if_a.first_bad_ref), 32'h00FF);
      chk("one_fbd_a",   32'(if_a.first_bad_dut), 32'h0101);
      chk("one_fbi_a",   32'(if_a.first_bad_idx), 32'd255);
      chk("one_diff_pk", 32'(last_nz_a),          32'h0002);
      chk("one_diff_a",  32'(if_a.diff_out),      32'h0000);
      chk("one_cnt_b",   32'(if_b.mismatch_cnt),  32'd1);
      chk("one_alarm_b", 32'(if_b.alarm),         32'd0);
      chk("one_fbi_b",   32'(if_b.first_bad_idx), 32'd255);

      // Three isolated corruptions against THRESH=3.
      do_reset();
      start_mon();
      run_ramp(29, 10, 20, 30, 16'h0001);
      chk("th3_mid_cnt_b",   32'(if_b.mismatch_cnt), 32'd2);
      chk("th3_mid_alarm_b", 32'(if_b.alarm),        32'd0);
      run_ramp(31, 10, 20, 30, 16'h0001);
      chk("th3_cnt_b",   32'(if_b.mismatch_cnt),  32'd3);
      chk("th3_alarm_b", 32'(if_b.alarm),         32'd1);
      chk("th3_fbi_b",   32'(if_b.first_bad_idx), 32'd10);
      chk("th3_fbr_b",   32'(if_b.first_bad_ref), 32'd10);
      chk("th3_fbi_a",   32'(if_a.first_bad_idx), 32'd10);

      // Continuous mismatch: counter saturation and diff wrap.
      do_reset();
      start_mon();
      for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0000);
      chk("sat_cnt_a",  32'(if_a.mismatch_cnt), 32'd255);
      chk("sat_cnt_b",  32'(if_b.mismatch_cnt), 32'd255);
      chk("sat_diff_a", 32'(if_a.diff_out),     32'hFFFF);
      chk("sat_fbr_a",  32'(if_a.first_bad_ref), 32'h0001);
      chk("sat_fbi_b",  32'(if_b.first_bad_idx), 32'd0);

      // Directed table.
      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].cl, tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].d);
         chk($sformatf("tbl%0d_state", i), 32'(if_a.state_out),    32'(tbl[i].st));
         chk($sformatf("tbl%0d_cnt", i),   32'(if_a.mismatch_cnt), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_alarm", i), 32'(if_a.alarm),        32'(tbl[i].al));
         chk($sformatf("tbl%0d_diff", i),  32'(if_a.diff_out),     32'(tbl[i].diff));
      end
      chk("tbl_fbr_a", 32'(if_a.first_bad_ref), 32'h0013);
      chk("tbl_fbd_a", 32'(if_a.first_bad_dut), 32'h0010);
      chk("tbl_fbi_a", 32'(if_a.first_bad_idx), 32'd0);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit          en;
         bit          cl;
         bit          v;
         logic [15:0] r;
         logic [15:0] dd [2];
         en = ($urandom_range(0, 99) < 95);
         cl = ($urandom_range(0, 99) < 2);
         v  = ($urandom_range(0, 3) != 0);
         r  = 16'($urandom);
         for (int k = 0; k < 2; k++) begin
            dd[k] = dly_ref(lat_k[k]);
            if ($urandom_range(0, 15) == 0) dd[k] = 16'($urandom);
         end
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         step(en, cl, v, r, dd[0], dd[1]);
         rst = 1'b0;
      end

      // Asynchronous reset between clock edges with nonzero state.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 16'h0000);
      chk("pre_rst_cnt_a", 32'(if_a.mismatch_cnt != 8'd0), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
